// File: rtl/mux_seq.sv
// mux_seq: registered CHANNELS:1 mux, manual select or timed scan; y/ch/valid one edge after inputs, no backpressure.
// Define MUX_SEQ_PARITY_EN to add a registered parity output that tracks the value loaded into y.
module mux_seq #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 3,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
`ifdef MUX_SEQ_PARITY_EN
  output logic                      parity,
`endif
  output logic                      wrap
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             sel_ok;
`ifdef MUX_SEQ_PARITY_EN
  logic             parity_q, parity_d;
`endif

  function automatic logic [WIDTH-1:0] pick(input logic [SEL_W-1:0] idx,
                                            input logic [CHANNELS*WIDTH-1:0] bus);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) res = bus[k*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  // Codes above CHANNELS-1 exist only when CHANNELS is not a power of two.
  assign sel_ok = (32'(sel) < 32'(CHANNELS));

  always_comb begin
    state_d = IDLE;
    if (en) state_d = mode ? SCAN : MANUAL;

    y_d     = y_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    chan_d  = '0;
    dwell_d = '0;

    case (state_d)
      MANUAL: begin
        ch_d = sel;
        if (sel_ok) begin
          y_d     = pick(sel, d);
          valid_d = 1'b1;
        end else begin
          y_d = '0;
        end
      end
      SCAN: begin
        // Entering scan always restarts at channel 0; position is never resumed.
        if (state_q != SCAN) begin
          chan_d  = '0;
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (chan_q == CH_LAST) begin
            chan_d = '0;
            wrap_d = 1'b1;
          end else begin
            chan_d = chan_q + 1'b1;
          end
        end else begin
          chan_d  = chan_q;
          dwell_d = dwell_q + 8'd1;
        end
        y_d     = pick(chan_d, d);
        ch_d    = chan_d;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MUX_SEQ_PARITY_EN
  always_comb begin
    parity_d = parity_q;
    if (state_d != IDLE) parity_d = ^y_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      y_q      <= '0;
      ch_q     <= '0;
      chan_q   <= '0;
      dwell_q  <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
`ifdef MUX_SEQ_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      ch_q     <= ch_d;
      chan_q   <= chan_d;
      dwell_q  <= dwell_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
`ifdef MUX_SEQ_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign y     = y_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;
`ifdef MUX_SEQ_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_seq.sv
// Scoreboard bench for mux_seq: four instances (8ch, 6ch, 4ch/dwell3, 4ch/dwell1) sharing control inputs.
module tb_mux_seq;

  logic clk = 1'b0;
  logic reset, en, mode;

  logic [2:0]  sel_a, sel_b;
  logic [1:0]  sel_c;
  logic [31:0] d_a;
  logic [23:0] d_b;
  logic [15:0] d_c;

  logic [3:0] y_a, y_b, y_c, y_e;
  logic [2:0] ch_a, ch_b;
  logic [1:0] ch_c, ch_e;
  logic v_a, v_b, v_c, v_e, w_a, w_b, w_c, w_e;
`ifdef MUX_SEQ_PARITY_EN
  logic p_a, p_b, p_c, p_e;
`endif

  always #5 clk = ~clk;

  mux_seq #(.WIDTH(4), .CHANNELS(8), .DWELL(3)) u_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel_a), .d(d_a),
    .y(y_a), .ch(ch_a), .valid(v_a),
`ifdef MUX_SEQ_PARITY_EN
    .parity(p_a),
`endif
    .wrap(w_a));

  mux_seq #(.WIDTH(4), .CHANNELS(6), .DWELL(3)) u_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel_b), .d(d_b),
    .y(y_b), .ch(ch_b), .valid(v_b),
`ifdef MUX_SEQ_PARITY_EN
    .parity(p_b),
`endif
    .wrap(w_b));

  mux_seq #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u_c (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel_c), .d(d_c),
    .y(y_c), .ch(ch_c), .valid(v_c),
`ifdef MUX_SEQ_PARITY_EN
    .parity(p_c),
`endif
    .wrap(w_c));

  mux_seq #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u_e (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel_c), .d(d_c),
    .y(y_e), .ch(ch_e), .valid(v_e),
`ifdef MUX_SEQ_PARITY_EN
    .parity(p_e),
`endif
    .wrap(w_e));

  typedef struct {
    int         inst;
    logic [3:0] y;
    logic [3:0] ch;
    logic       v;
    logic       w;
    logic       p;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] out_y(input int i);
    case (i)
      0: return y_a;
      1: return y_b;
      2: return y_c;
      default: return y_e;
    endcase
  endfunction

  function automatic logic [3:0] out_ch(input int i);
    case (i)
      0: return {1'b0, ch_a};
      1: return {1'b0, ch_b};
      2: return {2'b0, ch_c};
      default: return {2'b0, ch_e};
    endcase
  endfunction

  function automatic logic out_v(input int i);
    case (i)
      0: return v_a;
      1: return v_b;
      2: return v_c;
      default: return v_e;
    endcase
  endfunction

  function automatic logic out_w(input int i);
    case (i)
      0: return w_a;
      1: return w_b;
      2: return w_c;
      default: return w_e;
    endcase
  endfunction

  task automatic check_entry(input exp_t e);
    chk({e.nm, ".y"},     32'(out_y(e.inst)),  32'(e.y));
    chk({e.nm, ".ch"},    32'(out_ch(e.inst)), 32'(e.ch));
    chk({e.nm, ".valid"}, 32'(out_v(e.inst)),  32'(e.v));
    chk({e.nm, ".wrap"},  32'(out_w(e.inst)),  32'(e.w));
`ifdef MUX_SEQ_PARITY_EN
    if (e.inst == 2) chk({e.nm, ".parity"}, 32'(p_c), 32'(e.p));
`endif
  endtask

  task automatic push(input int inst, input int yv, input int chv, input bit v, input bit w,
                      input string nm);
    exp_t e;
    e.inst = inst;
    e.y    = 4'(yv);
    e.ch   = 4'(chv);
    e.v    = v;
    e.w    = w;
    e.p    = ^e.y;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // Monitor: each edge's outputs are checked against whatever was queued for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check_entry(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int dc(input int k);
    return 3 + 4 * k;
  endfunction

  int ctab[20] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0,0,1,1,1,2,2};

  initial begin
    exp_t z;
    reset = 1'b1; en = 1'b0; mode = 1'b0;
    sel_a = '0; sel_b = '0; sel_c = '0;
    for (int k = 0; k < 8; k++) d_a[k*4 +: 4] = 4'(k + 1);
    for (int k = 0; k < 6; k++) d_b[k*4 +: 4] = 4'(10 + k);
    for (int k = 0; k < 4; k++) d_c[k*4 +: 4] = 4'(dc(k));

    #1;
    z.y = '0; z.ch = '0; z.v = 1'b0; z.w = 1'b0; z.p = 1'b0;
    z.inst = 0; z.nm = "rst_a"; check_entry(z);
    z.inst = 2; z.nm = "rst_c"; check_entry(z);

    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0; en = 1'b1; mode = 1'b0; sel_a = 3'd5; sel_b = 3'd7;
    push(0, 6, 5, 1, 0, "man_sel5");
    push(1, 0, 7, 0, 0, "man_oor");

    step();
    sel_a = 3'd0; sel_b = 3'd2;
    push(0, 1, 0, 1, 0, "man_sel0");
    push(1, 12, 2, 1, 0, "man_sel2");

    step();
    en = 1'b0;
    push(0, 1, 0, 0, 0, "idle_a");
    push(1, 12, 2, 0, 0, "idle_b");

    step();
    en = 1'b1; mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      push(2, dc(ctab[i]), ctab[i], 1, i == 12, $sformatf("scan_c%0d", i));
      push(3, dc(i % 4), i % 4, 1, (i > 0) && (i % 4 == 0), $sformatf("scan_e%0d", i));
    end

    repeat (2) begin
      step();
      en = 1'b0;
      push(2, 11, 2, 0, 0, "freeze_c");
      push(3, 15, 3, 0, 0, "freeze_e");
    end

    step();
    en = 1'b1;
    push(2, 3, 0, 1, 0, "reentry_c");
    push(3, 3, 0, 1, 0, "reentry_e");

    step();
    push(2, 3, 0, 1, 0, "dwell_c");
    push(3, 7, 1, 1, 0, "adv_e");

    step();
    mode = 1'b0; sel_c = 2'd2;
    push(2, 11, 2, 1, 0, "scan2man_c");
    push(3, 11, 2, 1, 0, "scan2man_e");

    step();
    mode = 1'b1;
    push(2, 3, 0, 1, 0, "man2scan_c");
    push(3, 3, 0, 1, 0, "man2scan_e");

    step();
    #1 reset = 1'b1;
    #1;
    z.inst = 2; z.nm = "async_rst_c"; check_entry(z);
    z.inst = 3; z.nm = "async_rst_e"; check_entry(z);
    #1 reset = 1'b0;
    push(2, 3, 0, 1, 0, "post_rst_c");
    push(3, 3, 0, 1, 0, "post_rst_e");

    step();
    push(2, 3, 0, 1, 0, "post_rst2_c");
    push(3, 7, 1, 1, 0, "post_rst2_e");

    step();
    step();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_seq.md
MUX_SEQ -- requirements
Module: mux_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data bits per channel (1..32).
REQ-002 The block SHALL have parameter CHANNELS, default 8, giving the input channel count (2..16).
REQ-003 The block SHALL have parameter DWELL, default 3, giving the cycles spent on each channel in scan mode (1..255).
REQ-004 The block SHALL derive SEL_W = clog2(CHANNELS) internally; it is not a port parameter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: block enable.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 selects manual mode, 1 selects automatic scan mode.
REQ-009 The block SHALL have port sel, input, SEL_W bits: channel select, used in manual mode only.
REQ-010 The block SHALL have port d, input, CHANNELS*WIDTH bits: packed channel data; channel k occupies d[k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port y, output, WIDTH bits: registered selected data.
REQ-012 The block SHALL have port ch, output, SEL_W bits: index of the channel currently presented on y.
REQ-013 The block SHALL have port valid, output, 1 bit: y/ch hold a legal sample this cycle.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on scan wrap-around.

Function
REQ-015 The FSM SHALL have three states: IDLE, MANUAL and SCAN.
REQ-016 On every rising edge, the next state SHALL be IDLE if en=0, else MANUAL if mode=0, else SCAN.
REQ-017 In IDLE, y and ch SHALL hold their values and valid=0, wrap=0.
REQ-018 In MANUAL with sel<CHANNELS, the edge SHALL register y<=d[sel], ch<=sel and valid<=1, giving latency of exactly 1 cycle from sel/d to y.
REQ-019 In MANUAL with sel>=CHANNELS, the edge SHALL register y<=0, ch<=sel and valid<=0.
REQ-020 In SCAN, the block SHALL keep a channel counter and a dwell counter, and y<=d[channel counter] SHALL update every cycle so that live data is tracked, with valid=1.
REQ-021 In SCAN, when the dwell counter reaches DWELL-1 it SHALL clear, and the channel counter SHALL advance by 1.
REQ-022 In SCAN, the channel counter SHALL advance from CHANNELS-1 to 0 (never to unused codes), with wrap=1 for the single cycle in which ch first shows 0 after a wrap.
REQ-023 On entry to SCAN from any other state, the block SHALL reset the channel counter and dwell counter to 0, and the first registered output SHALL be channel 0; entry SHALL NOT assert wrap.
REQ-024 When switching SCAN->MANUAL, the block SHALL discard the scan position, and the next edge SHALL present d[sel].
REQ-025 When en deasserts mid-dwell, the block SHALL freeze outputs; re-enable SHALL restart per REQ-023 (no resume).
REQ-026 With DWELL=1, the channel SHALL advance every cycle.

Reset
REQ-027 Asserting reset SHALL immediately, independent of clk, force state=IDLE, y=0, ch=0, valid=0, wrap=0 and both counters=0.
REQ-028 Reset asserted mid-scan or mid-dwell SHALL discard all progress; after release, behaviour SHALL follow REQ-016 from the first edge.
REQ-029 The first edge after release SHALL be the first edge that updates state.

Configuration
REQ-030 With macro MUX_SEQ_PARITY_EN defined, the block SHALL add output port parity (1 bit), registered alongside y, equal to XOR of the bits of the value loaded into y; parity SHALL reset to 0 and hold in IDLE.
REQ-031 Without MUX_SEQ_PARITY_EN, the block SHALL have no parity port and no parity logic; all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover: reset held with CHANNELS=8, WIDTH=4, then en=1, mode=0, sel=5, d channel k = k+1 -> one edge later y=6, ch=5, valid=1.
REQ-033 The bench SHALL cover: CHANNELS=6, mode=0, sel=7 -> y=0, valid=0, ch=7; then sel=2 -> next edge y=d2, valid=1.
REQ-034 The bench SHALL cover: CHANNELS=4, DWELL=3, mode=1 for 14 cycles -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0,0 and wrap=1 only on the 13th output cycle.
REQ-035 The bench SHALL cover: scan at ch=2 mid-dwell, then en=0 for 2 cycles -> y/ch frozen, valid=0; en=1 -> ch=0 and wrap=0.
REQ-036 The bench SHALL cover: reset pulsed between clock edges during SCAN -> y=0, ch=0, valid=0 immediately, before the next edge.
REQ-037 With MUX_SEQ_PARITY_EN, when y loads 4'b1011, the bench SHALL see parity=1 in the same cycle as y.
